// File: rtl/writeback_pkg.sv
// ============================================================================
// Module   : writeback_pkg
// Brief    : Opcode, load-funct3 and width constants shared by decode, memory
//            and writeback stages, plus the load-data extension helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package writeback_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Raw load data arrives zero-filled above the access size.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] ext;
        ext = raw;
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){raw[7]}},   raw[7:0]};
            F3_LH:   ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_LW:   ext = {{(XLEN-32){raw[31]}}, raw[31:0]};
            F3_LBU:  ext = {{(XLEN-8){1'b0}},     raw[7:0]};
            F3_LHU:  ext = {{(XLEN-16){1'b0}},    raw[15:0]};
            F3_LWU:  ext = {{(XLEN-32){1'b0}},    raw[31:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_regfile.sv
// ============================================================================
// Module   : writeback_regfile
// Brief    : 32x64 architectural register file, 2R1W, x0 hardwired to zero,
//            write-through bypass on both read ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_regfile
    import writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Bypass lets decode see a value being written in this same cycle.
    always_comb begin
        rdata1 = regs_q[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end

        rdata2 = regs_q[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback.sv
// ============================================================================
// Module   : writeback
// Brief    : Final pipeline stage: load extension, writeback select, register
//            file, and control-flow resolve back to fetch.
//            Optional retire/branch counters under `WB_RETIRE_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback
    import writeback_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WB_V,
    input  logic [3:0]        WB_Cst,
    input  logic [XLEN-1:0]   WB_RES,
    input  logic              WB_PC_MUX,
    input  logic [XLEN-1:0]   WB_NPC,
    input  logic [31:0]       WB_IR,
    input  logic [XLEN-1:0]   WB_Target_Address,
    input  logic [REG_AW-1:0] DE_SR1,
    input  logic [REG_AW-1:0] DE_SR2,
    output logic [XLEN-1:0]   DE_SR1_DATA,
    output logic [XLEN-1:0]   DE_SR2_DATA,
    output logic [REG_AW-1:0] WB_DR,
    output logic              WB_LD_REG,
    output logic              WB_FE_PC_LD,
    output logic [XLEN-1:0]   WB_FE_PC,
    output logic              WB_FE_BR_RESOLVE
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       WB_RETIRED,
    output logic [31:0]       WB_BR_TAKEN_CNT
`endif
);

    logic [4:0]      opcode;
    logic            is_wr_opc;
    logic            is_ctrl;
    logic            resolve_v;
    logic [XLEN-1:0] wb_value;

    logic            fe_pc_ld_d,      fe_pc_ld_q;
    logic            fe_br_resolve_d, fe_br_resolve_q;
    logic [XLEN-1:0] fe_pc_d,         fe_pc_q;

    // Control-store bits and immediate fields are carried, not decoded here.
    logic unused_inputs;
    assign unused_inputs = ^{WB_Cst, WB_IR[31:15], WB_IR[1:0]};

    assign opcode    = WB_IR[6:2];
    assign WB_DR     = WB_IR[11:7];
    assign WB_LD_REG = WB_V & is_wr_opc & (WB_DR != '0);

    always_comb begin
        is_wr_opc = 1'b0;
        is_ctrl   = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32,
            OPC_OP, OPC_LUI, OPC_OP32: is_wr_opc = 1'b1;
            OPC_JALR, OPC_JAL: begin
                is_wr_opc = 1'b1;
                is_ctrl   = 1'b1;
            end
            OPC_BRANCH: is_ctrl = 1'b1;
            default: ;
        endcase

        case (opcode)
            OPC_JAL, OPC_JALR: wb_value = WB_NPC;
            OPC_LOAD:          wb_value = load_extend(WB_IR[14:12], WB_RES);
            default:           wb_value = WB_RES;
        endcase

        resolve_v       = WB_V & is_ctrl;
        fe_br_resolve_d = resolve_v;
        fe_pc_ld_d      = resolve_v & WB_PC_MUX;
        fe_pc_d         = resolve_v ? WB_Target_Address : fe_pc_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fe_pc_ld_q      <= 1'b0;
            fe_br_resolve_q <= 1'b0;
            fe_pc_q         <= '0;
        end else begin
            fe_pc_ld_q      <= fe_pc_ld_d;
            fe_br_resolve_q <= fe_br_resolve_d;
            fe_pc_q         <= fe_pc_d;
        end
    end

    assign WB_FE_PC_LD      = fe_pc_ld_q;
    assign WB_FE_BR_RESOLVE = fe_br_resolve_q;
    assign WB_FE_PC         = fe_pc_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_d, retired_q;
    logic [31:0] br_taken_d, br_taken_q;

    always_comb begin
        retired_d  = retired_q + {63'd0, WB_V};
        br_taken_d = br_taken_q + {31'd0, resolve_v & WB_PC_MUX};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            retired_q  <= '0;
            br_taken_q <= '0;
        end else begin
            retired_q  <= retired_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign WB_RETIRED      = retired_q;
    assign WB_BR_TAKEN_CNT = br_taken_q;
`endif

    writeback_regfile u_regfile (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .we     (WB_LD_REG),
        .waddr  (WB_DR),
        .wdata  (wb_value),
        .raddr1 (DE_SR1),
        .raddr2 (DE_SR2),
        .rdata1 (DE_SR1_DATA),
        .rdata2 (DE_SR2_DATA)
    );

endmodule

`default_nettype wire

// File: tb/tb_writeback.sv
// ============================================================================
// Module   : tb_writeback
// Brief    : Self-checking bench for writeback: directed cases plus random
//            instruction stream against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_writeback;
    import writeback_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        WB_V = 1'b0;
    logic [3:0]  WB_Cst = '0;
    logic [63:0] WB_RES = '0;
    logic        WB_PC_MUX = 1'b0;
    logic [63:0] WB_NPC = '0;
    logic [31:0] WB_IR = '0;
    logic [63:0] WB_Target_Address = '0;
    logic [4:0]  DE_SR1 = '0;
    logic [4:0]  DE_SR2 = '0;
    logic [63:0] DE_SR1_DATA, DE_SR2_DATA;
    logic [4:0]  WB_DR;
    logic        WB_LD_REG, WB_FE_PC_LD, WB_FE_BR_RESOLVE;
    logic [63:0] WB_FE_PC;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] WB_RETIRED;
    logic [31:0] WB_BR_TAKEN_CNT;
`endif

    writeback dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .WB_V              (WB_V),
        .WB_Cst            (WB_Cst),
        .WB_RES            (WB_RES),
        .WB_PC_MUX         (WB_PC_MUX),
        .WB_NPC            (WB_NPC),
        .WB_IR             (WB_IR),
        .WB_Target_Address (WB_Target_Address),
        .DE_SR1            (DE_SR1),
        .DE_SR2            (DE_SR2),
        .DE_SR1_DATA       (DE_SR1_DATA),
        .DE_SR2_DATA       (DE_SR2_DATA),
        .WB_DR             (WB_DR),
        .WB_LD_REG         (WB_LD_REG),
        .WB_FE_PC_LD       (WB_FE_PC_LD),
        .WB_FE_PC          (WB_FE_PC),
        .WB_FE_BR_RESOLVE  (WB_FE_BR_RESOLVE)
`ifdef WB_RETIRE_CNT_EN
        ,
        .WB_RETIRED        (WB_RETIRED),
        .WB_BR_TAKEN_CNT   (WB_BR_TAKEN_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    logic [63:0] m_regs [32];
    bit          m_resolve;
    bit          m_pc_ld;
    logic [63:0] m_pc;
    logic [63:0] m_retired;
    logic [31:0] m_brcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_writes(input logic [4:0] op);
        return op inside {OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_OP,
                          OPC_LUI, OPC_OP32, OPC_JALR, OPC_JAL};
    endfunction

    function automatic bit m_ctrl(input logic [4:0] op);
        return op inside {OPC_BRANCH, OPC_JALR, OPC_JAL};
    endfunction

    // Extension by size/signedness arithmetic: mask to the access size, then
    // subtract 2^bits when the value lies in the upper (negative) half.
    function automatic logic [63:0] m_value();
        logic [4:0]  op;
        logic [2:0]  f3;
        int          bytes;
        logic [63:0] v;
        op = WB_IR[6:2];
        f3 = WB_IR[14:12];
        if (op == OPC_JAL || op == OPC_JALR) return WB_NPC;
        if (op != OPC_LOAD) return WB_RES;
        bytes = 1 << f3[1:0];
        if (bytes == 8) return WB_RES;
        v = WB_RES % (64'd1 << (8 * bytes));
        if (!f3[2] && v >= (64'd1 << (8 * bytes - 1))) v = v - (64'd1 << (8 * bytes));
        return v;
    endfunction

    function automatic bit m_ld_reg();
        return WB_V && m_writes(WB_IR[6:2]) && (WB_IR[11:7] != 5'd0);
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (m_ld_reg() && idx == WB_IR[11:7]) return m_value();
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3);
        return {$urandom_range(0, 131071) & 32'h1FFFF, 15'd0}
               | {17'd0, f3, rd, op, 2'b11};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_resolve = 0; m_pc_ld = 0; m_pc = '0; m_retired = '0; m_brcnt = '0;
    end

    always @(negedge RESET_N) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_resolve = 0; m_pc_ld = 0; m_pc = '0; m_retired = '0; m_brcnt = '0;
    end

    always @(posedge CLK) begin
        if (RESET_N) begin
            bit ctl;
            ctl = WB_V && m_ctrl(WB_IR[6:2]);
            if (m_ld_reg()) m_regs[WB_IR[11:7]] = m_value();
            m_resolve = ctl;
            m_pc_ld   = ctl && WB_PC_MUX;
            if (ctl) m_pc = WB_Target_Address;
            if (WB_V) m_retired = m_retired + 64'd1;
            if (ctl && WB_PC_MUX) m_brcnt = m_brcnt + 32'd1;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("ld_reg",  {63'd0, WB_LD_REG},        {63'd0, m_ld_reg()});
            chk("dr",      {59'd0, WB_DR},            {59'd0, WB_IR[11:7]});
            chk("sr1",     DE_SR1_DATA,               m_read(DE_SR1));
            chk("sr2",     DE_SR2_DATA,               m_read(DE_SR2));
            chk("pc_ld",   {63'd0, WB_FE_PC_LD},      {63'd0, m_pc_ld});
            chk("resolve", {63'd0, WB_FE_BR_RESOLVE}, {63'd0, m_resolve});
            chk("fe_pc",   WB_FE_PC,                  m_pc);
`ifdef WB_RETIRE_CNT_EN
            chk("retired", WB_RETIRED,                m_retired);
            chk("brcnt",   {32'd0, WB_BR_TAKEN_CNT},  {32'd0, m_brcnt});
`endif
        end
    end

    // Presents one instruction for a cycle; returns 1ns after the capturing edge.
    task automatic drive(input bit v, input logic [31:0] ir, input logic [63:0] res,
                         input logic [63:0] npc, input logic [63:0] tgt, input bit mux);
        WB_V = v; WB_IR = ir; WB_RES = res; WB_NPC = npc;
        WB_Target_Address = tgt; WB_PC_MUX = mux; WB_Cst = 4'($urandom);
        @(posedge CLK); #1;
        WB_V = 1'b0;
    endtask

    logic [4:0] opc_pool [10];

    initial begin
        opc_pool = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_OP,
                     OPC_LUI, OPC_OP32, OPC_BRANCH, OPC_JALR, OPC_JAL};
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        chk_on = 1'b1;

        // 1: all zero after reset, then a simple write
        for (int i = 0; i < 32; i++) begin
            DE_SR1 = 5'(i); DE_SR2 = 5'(31 - i);
            #1;
            chk("rst_sr1", DE_SR1_DATA, 64'd0);
            chk("rst_sr2", DE_SR2_DATA, 64'd0);
            @(posedge CLK); #1;
        end
        chk("rst_pc", WB_FE_PC, 64'd0);
        drive(1, mk_ir(OPC_OP, 5'd5, 3'd0), 64'h1234, 64'h0, 64'h0, 0);
        DE_SR1 = 5'd5; #1;
        chk("x5", DE_SR1_DATA, 64'h1234);

        // 2: load extension
        drive(1, mk_ir(OPC_LOAD, 5'd7, 3'b000), 64'h80, 64'h0, 64'h0, 0);
        DE_SR1 = 5'd7; #1;
        chk("lb", DE_SR1_DATA, 64'hFFFF_FFFF_FFFF_FF80);
        @(posedge CLK); #1;
        drive(1, mk_ir(OPC_LOAD, 5'd7, 3'b100), 64'h80, 64'h0, 64'h0, 0);
        #1 chk("lbu", DE_SR1_DATA, 64'h80);
        @(posedge CLK); #1;
        drive(1, mk_ir(OPC_LOAD, 5'd7, 3'b110), 64'h8000_0000, 64'h0, 64'h0, 0);
        #1 chk("lwu", DE_SR1_DATA, 64'h0000_0000_8000_0000);
        @(posedge CLK); #1;

        // 3: x0 and invalid bundles
        WB_V = 1; WB_IR = mk_ir(OPC_OP, 5'd0, 3'd0); WB_RES = 64'hDEAD; #1;
        chk("rd0_ld", {63'd0, WB_LD_REG}, 64'd0);
        @(posedge CLK); #1;
        WB_V = 0; DE_SR1 = 5'd0; #1;
        chk("x0", DE_SR1_DATA, 64'd0);
        @(posedge CLK); #1;
        drive(0, mk_ir(OPC_OP, 5'd3, 3'd0), 64'hBEEF, 64'h0, 64'h0, 0);
        DE_SR1 = 5'd3; #1;
        chk("x3", DE_SR1_DATA, 64'd0);
        @(posedge CLK); #1;

        // 4: taken JAL
        drive(1, mk_ir(OPC_JAL, 5'd1, 3'd0), 64'h77, 64'h1004, 64'h2000, 1);
        DE_SR1 = 5'd1; #1;
        chk("x1", DE_SR1_DATA, 64'h1004);
        chk("jal_ld", {63'd0, WB_FE_PC_LD}, 64'd1);
        chk("jal_pc", WB_FE_PC, 64'h2000);
        chk("jal_res", {63'd0, WB_FE_BR_RESOLVE}, 64'd1);
        @(posedge CLK); #1;
        chk("jal_ld_drop", {63'd0, WB_FE_PC_LD}, 64'd0);
        chk("jal_res_drop", {63'd0, WB_FE_BR_RESOLVE}, 64'd0);
        chk("jal_pc_hold", WB_FE_PC, 64'h2000);

        // 5: not-taken branch, then dual bypass
        drive(1, mk_ir(OPC_BRANCH, 5'd9, 3'd0), 64'h99, 64'h0, 64'h3000, 0);
        DE_SR1 = 5'd9; #1;
        chk("br_res", {63'd0, WB_FE_BR_RESOLVE}, 64'd1);
        chk("br_ld", {63'd0, WB_FE_PC_LD}, 64'd0);
        chk("br_nowr", DE_SR1_DATA, 64'd0);
        WB_V = 1; WB_IR = mk_ir(OPC_OP, 5'd9, 3'd0); WB_RES = 64'h55;
        DE_SR1 = 5'd9; DE_SR2 = 5'd9; #1;
        chk("byp1", DE_SR1_DATA, 64'h55);
        chk("byp2", DE_SR2_DATA, 64'h55);
        @(posedge CLK); #1;

        // Random stream
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : opc_pool[$urandom_range(0, 9)];
            WB_V = ($urandom_range(0, 3) != 0);
            WB_IR = $urandom;
            WB_IR[6:2] = op;
            if ($urandom_range(0, 1) == 1) WB_IR[11:7] = 5'($urandom_range(0, 5));
            WB_RES = {$urandom, $urandom};
            WB_NPC = {$urandom, $urandom};
            WB_Target_Address = {$urandom, $urandom};
            WB_PC_MUX = 1'($urandom);
            WB_Cst = 4'($urandom);
            DE_SR1 = ($urandom_range(0, 1) == 1) ? WB_IR[11:7] : 5'($urandom);
            DE_SR2 = 5'($urandom_range(0, 5));
            @(posedge CLK); #1;
        end

        // 6: async reset during a JAL
        WB_V = 0;
        drive(1, mk_ir(OPC_JAL, 5'd1, 3'd0), 64'h0, 64'h1004, 64'h4000, 1);
        WB_V = 1; WB_IR = mk_ir(OPC_JAL, 5'd2, 3'd0); WB_NPC = 64'h5004;
        WB_Target_Address = 64'h6000; WB_PC_MUX = 1;
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_ld", {63'd0, WB_FE_PC_LD}, 64'd0);
        chk("rst_res", {63'd0, WB_FE_BR_RESOLVE}, 64'd0);
        chk("rst_fepc", WB_FE_PC, 64'd0);
        WB_V = 0; DE_SR1 = 5'd1; DE_SR2 = 5'd2; #1;
        chk("rst_x1", DE_SR1_DATA, 64'd0);
        chk("rst_x2", DE_SR2_DATA, 64'd0);
        WB_V = 1;
        @(posedge CLK); #1;
        WB_V = 0;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        chk("post_res", {63'd0, WB_FE_BR_RESOLVE}, 64'd0);
        chk("post_ld", {63'd0, WB_FE_PC_LD}, 64'd0);
        chk("post_x2", DE_SR2_DATA, 64'd0);

`ifdef WB_RETIRE_CNT_EN
        for (int k = 0; k < 10; k++) begin
            if (k == 1 || k == 4 || k == 7)
                drive(1, mk_ir(OPC_JAL, 5'd4, 3'd0), 64'h0, 64'h100, 64'h200, 1);
            else if (k == 5)
                drive(1, mk_ir(OPC_BRANCH, 5'd0, 3'd0), 64'h0, 64'h0, 64'h300, 0);
            else
                drive(1, mk_ir(OPC_OP, 5'd6, 3'd0), 64'(k), 64'h0, 64'h0, 1);
        end
        chk("retired10", WB_RETIRED, 64'd10);
        chk("brcnt3", {32'd0, WB_BR_TAKEN_CNT}, 64'd3);
`endif

        repeat (3) @(posedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage. Consumes the registered WB_* bundle produced by the memory stage.
- Holds the 32x64 architectural register file: two combinational read ports for decode, one write port.
- Performs load-data extension and selects the writeback value.
- Resolves control-flow instructions back to fetch by redirecting the PC and releasing the branch stall raised in MEM.

Parameters:
XLEN, 64, datapath width
NREGS, 32, register count (index width = 5)

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous, active-low reset
WB_V  in  1  WB bundle valid
WB_Cst  in  4  control store bits; carried only, not decoded here
WB_RES  in  64  ALU result, or raw load data from memoryFile (zero-filled above access size)
WB_PC_MUX  in  1  1 = control-flow taken, target valid
WB_NPC  in  64  PC+4 of the instruction
WB_IR  in  32  instruction
WB_Target_Address  in  64  branch/jump target
DE_SR1  in  5  decode read index 1
DE_SR2  in  5  decode read index 2
DE_SR1_DATA  out  64  read data 1
DE_SR2_DATA  out  64  read data 2
WB_DR  out  5  destination index (combinational, WB_IR[11:7])
WB_LD_REG  out  1  register write enable this cycle (combinational; used for dependency checks)
WB_FE_PC_LD  out  1  registered pulse: fetch loads WB_FE_PC
WB_FE_PC  out  64  registered redirect PC
WB_FE_BR_RESOLVE  out  1  registered pulse: branch resolved, fetch releases stall

Behaviour:
- Opcode is WB_IR[6:2]. LOAD=00000, OP-IMM=00100, AUIPC=00101, OP-IMM-32=00110, OP=01100, LUI=01101, OP-32=01110, BRANCH=11000, JALR=11001, JAL=11011.
- WB_LD_REG = WB_V & (opcode in {LOAD, OP-IMM, AUIPC, OP-IMM-32, OP, LUI, OP-32, JALR, JAL}) & (WB_DR != 0).
- Writeback value:
  - JAL/JALR: WB_NPC.
  - LOAD: WB_RES extended per WB_IR[14:12]: 000 sext8, 001 sext16, 010 sext32, 011 pass, 100 zext8, 101 zext16, 110 zext32, 111 pass.
  - Otherwise: WB_RES.
- Write occurs at posedge CLK when WB_LD_REG is 1.
- x0 is never written; a read of index 0 always returns 0.
- Reads are combinational with write-through bypass: if WB_LD_REG and DE_SRn == WB_DR (nonzero), DE_SRn_DATA returns the in-flight writeback value. Both ports may bypass in the same cycle.
- Control resolve, registered, one-cycle latency:
  - When WB_V and opcode in {BRANCH, JALR, JAL}, the next cycle has WB_FE_BR_RESOLVE=1, WB_FE_PC_LD=WB_PC_MUX, WB_FE_PC=WB_Target_Address.
  - Otherwise both pulses are 0 and WB_FE_PC holds its value.
  - Pulses last exactly one cycle each; back-to-back control instructions give back-to-back pulses.
- WB_V=0: no write, no pulses, regardless of other inputs (X on data inputs must not propagate).
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - All 32 registers, WB_FE_PC_LD, WB_FE_BR_RESOLVE and WB_FE_PC go to 0.
  - Assertion mid-write aborts the write.
  - Pulses are suppressed while RESET_N=0.

Optional Feature:
WB_RETIRE_CNT_EN:
- When defined, adds two outputs: WB_RETIRED (64, instructions retired) and WB_BR_TAKEN_CNT (32).
- WB_RETIRED increments by 1 for each cycle with WB_V=1. WB_BR_TAKEN_CNT increments for each resolved control instruction with WB_PC_MUX=1.
- Both reset to 0 and wrap modulo 2^width.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_OP, OPC_LUI, OPC_OP32, OPC_BRANCH, OPC_JALR, OPC_JAL).
  - load funct3 constants.
  - XLEN.
  - These are shared with the decode and memory stages.
- One sub-module, regfile: 32x64 storage, 2R1W, x0 hardwired, write-through bypass, async active-low reset.
- Extension, select and resolve logic live in writeback.

Test Plan:
1. Reset, then read all indices -> every DE_SRn_DATA = 0. Write x5=0x1234 (OP, WB_RES=0x1234), next cycle read x5 -> 0x1234.
2. LOAD with funct3=000, WB_RES=0x80 into x7 -> x7=0xFFFF_FFFF_FFFF_FF80. Same with funct3=100 -> x7=0x80. Same with funct3=110, WB_RES=0x8000_0000 -> x7=0x0000_0000_8000_0000.
3. OP with rd=0, WB_RES=0xDEAD -> WB_LD_REG=0, and x0 still reads 0. Same instruction with WB_V=0 and rd=3 -> x3 unchanged.
4. JAL rd=1, NPC=0x1004, target=0x2000, PC_MUX=1 -> x1=0x1004. Next cycle WB_FE_PC_LD=1, WB_FE_PC=0x2000, RESOLVE=1; all drop the following cycle.
5. Not-taken BRANCH (PC_MUX=0) -> RESOLVE=1, PC_LD=0, no register write. Same-cycle write x9=0x55 with DE_SR1=DE_SR2=9 -> both ports read 0x55 via bypass.
6. RESET_N pulled low mid-stream during a JAL -> outputs and registers are 0 immediately, and no pulses appear after release. With WB_RETIRE_CNT_EN defined, 10 valid instructions including 3 taken branches -> WB_RETIRED=10, WB_BR_TAKEN_CNT=3.
